// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: sequencer control inputs and per-domain reset outputs
interface reset_sequencer_if #(
    parameter int STAGES = 4
);
    localparam int IW = STAGES > 1 ? $clog2(STAGES) : 1;
    logic              soft_reset;
    logic [STAGES-1:0] stage_ready;
    logic [STAGES-1:0] reset_out;
    logic              all_released;
    logic              timeout_err;
    logic [IW-1:0]     fail_stage;
    modport master (
        input  soft_reset, stage_ready,
        output reset_out, all_released, timeout_err, fail_stage
    );
    modport slave (
        output soft_reset, stage_ready,
        input  reset_out, all_released, timeout_err, fail_stage
    );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases downstream reset domains one at a time with a stretch delay and a ready watchdog
module reset_sequencer #(
    parameter int STAGES  = 4,
    parameter int DELAY   = 7,
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic reset_in,
    reset_sequencer_if.master bus
);
    localparam int IW = STAGES > 1 ? $clog2(STAGES) : 1;
    localparam int DW = DELAY > 0 ? $clog2(DELAY + 1) : 1;
    localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(STAGES - 1);
    localparam logic [DW-1:0] DLOAD = DW'(DELAY);
    localparam logic [WW-1:0] WLAST = WW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    typedef enum logic [1:0] {S_DELAY, S_WAIT, S_DONE, S_FAULT} state_t;
    state_t            state, state_d;
    logic [IW-1:0]     idx, idx_d;
    logic [DW-1:0]     dcnt, dcnt_d;
    logic [WW-1:0]     wcnt, wcnt_d;
    logic [STAGES-1:0] rst_q, rst_d;
    logic              rel_q, rel_d;
    logic              err_q, err_d;
    logic [IW-1:0]     fs_q, fs_d;
    // State and output registers; reset_in clears everything including the sticky error
    always_ff @(posedge clk) begin
        if (reset_in) begin
            state <= S_DELAY;
            idx   <= '0;
            dcnt  <= DLOAD;
            wcnt  <= '0;
            rst_q <= '1;
            rel_q <= 1'b0;
            err_q <= 1'b0;
            fs_q  <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            dcnt  <= dcnt_d;
            wcnt  <= wcnt_d;
            rst_q <= rst_d;
            rel_q <= rel_d;
            err_q <= err_d;
            fs_q  <= fs_d;
        end
    end
    // Next state: soft_reset restarts the sequence but keeps the error record; ready beats the watchdog
    always_comb begin
        state_d = state;
        idx_d   = idx;
        dcnt_d  = dcnt;
        wcnt_d  = wcnt;
        rst_d   = rst_q;
        rel_d   = rel_q;
        err_d   = err_q;
        fs_d    = fs_q;
        if (bus.soft_reset) begin
            state_d = S_DELAY;
            idx_d   = '0;
            dcnt_d  = DLOAD;
            wcnt_d  = '0;
            rst_d   = '1;
            rel_d   = 1'b0;
        end else begin
            case (state)
                S_DELAY: begin
                    if (dcnt == '0) begin
                        rst_d[idx] = 1'b0;
                        wcnt_d     = '0;
                        state_d    = S_WAIT;
                    end else begin
                        dcnt_d = dcnt - DW'(1);
                    end
                end
                S_WAIT: begin
                    if (bus.stage_ready[idx]) begin
                        if (idx == LAST_IDX) begin
                            state_d = S_DONE;
                            rel_d   = 1'b1;
                        end else begin
                            idx_d   = idx + IW'(1);
                            dcnt_d  = DLOAD;
                            state_d = S_DELAY;
                        end
                    end else if (TIMEOUT != 0 && wcnt == WLAST) begin
                        state_d = S_FAULT;
                        rst_d   = '1;
                        err_d   = 1'b1;
                        fs_d    = idx;
                    end else begin
                        wcnt_d = wcnt + WW'(1);
                    end
                end
                S_DONE: begin
                    rst_d = '0;
                    rel_d = 1'b1;
                end
                default: begin
                    rst_d = '1;
                    rel_d = 1'b0;
                end
            endcase
        end
    end
    assign bus.reset_out    = rst_q;
    assign bus.all_released = rel_q;
    assign bus.timeout_err  = err_q;
    assign bus.fail_stage   = fs_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: scoreboard bench comparing the sequencer against a stage-timeline model
module tb_reset_sequencer;
    localparam int S = 3;
    localparam int D = 3;
    localparam int T = 10;
    logic clk = 1'b0;
    logic reset_in;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [6:0] exp_q[$];
    reset_sequencer_if #(.STAGES(S)) bus ();
    reset_sequencer #(.STAGES(S), .DELAY(D), .TIMEOUT(T)) dut (
        .clk(clk),
        .reset_in(reset_in),
        .bus(bus.master)
    );
    always #5 clk = ~clk;
    // Model: each stage has an entry edge; release at entry+D+1, then up to T ready samples
    int m_edge = 0;
    int m_t0 = 0;
    int m_k = 0;
    bit m_done = 0;
    bit m_fault = 0;
    bit m_err = 0;
    logic [1:0] m_fs = 0;
    logic [S-1:0] m_rst = '1;
    task automatic tick();
        int d;
        @(posedge clk);
        m_edge++;
        if (reset_in || bus.soft_reset) begin
            m_k = 0;
            m_t0 = m_edge;
            m_done = 0;
            m_fault = 0;
            m_rst = '1;
            if (reset_in) begin
                m_err = 0;
                m_fs = 0;
            end
        end else if (!m_done && !m_fault) begin
            d = m_edge - m_t0;
            if (d == D + 1) begin
                m_rst[m_k] = 1'b0;
            end else if (d > D + 1) begin
                if (bus.stage_ready[m_k]) begin
                    if (m_k == S - 1) m_done = 1;
                    else begin
                        m_k++;
                        m_t0 = m_edge;
                    end
                end else if (T != 0 && d - D - 1 == T) begin
                    m_fault = 1;
                    m_rst = '1;
                    m_err = 1;
                    m_fs = 2'(m_k);
                end
            end
        end
        exp_q.push_back({m_rst, m_done, m_err, m_fs});
        #1;
    endtask
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask
    // Monitor: every cycle the DUT presents a full output set; compare against the oldest prediction
    always @(negedge clk) begin
        logic [6:0] e;
        logic [6:0] a;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.reset_out, bus.all_released, bus.timeout_err, bus.fail_stage};
            checks++;
            if (a !== e)
            begin
                failures++;
                $display("FAIL outputs cycle %0d: got rst=%b rel=%b err=%b fs=%0d, expected rst=%b rel=%b err=%b fs=%0d",
                         cyc, a[6:4], a[3], a[2], a[1:0], e[6:4], e[3], e[2], e[1:0]);
            end
        end
    end
    initial begin
        reset_in = 1'b1;
        bus.soft_reset = 1'b0;
        bus.stage_ready = '0;
        ticks(5);
        bus.stage_ready = 3'b111;
        reset_in = 1'b0;
        ticks(20);
        reset_in = 1'b1;
        ticks(2);
        bus.stage_ready = '0;
        reset_in = 1'b0;
        ticks(36);
        bus.stage_ready = 3'b111;
        bus.soft_reset = 1'b1;
        tick();
        bus.soft_reset = 1'b0;
        ticks(20);
        reset_in = 1'b1;
        bus.stage_ready = '0;
        tick();
        reset_in = 1'b0;
        ticks(13);
        bus.stage_ready = 3'b001;
        tick();
        bus.stage_ready = 3'b111;
        ticks(20);
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        ticks(6);
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        ticks(20);
        for (int i = 0; i < 600; i++) begin
            bus.stage_ready = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
            bus.soft_reset = ($urandom_range(0, 39) == 0);
            reset_in = ($urandom_range(0, 79) == 0);
            tick();
        end
        reset_in = 1'b0;
        bus.soft_reset = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
